// File: rtl/game_pkg.sv
// Shared types and constants for the game countdown timer slice.
package game_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_COUNTING = 2'd1,
      ST_PAUSED   = 2'd2,
      ST_EXPIRED  = 2'd3
   } timer_state_e;

   localparam int unsigned GAME_SECONDS_DEF = 30;
   localparam int unsigned WARN_SECONDS_DEF = 5;

   function automatic int unsigned cnt_width(input int unsigned game_seconds);
      return (game_seconds < 2) ? 1 : $clog2(game_seconds + 1);
   endfunction

   // Two-digit BCD of a constant below 100, tens in the upper nibble.
   function automatic logic [7:0] to_bcd(input int unsigned v);
      logic [3:0] tens;
      logic [3:0] ones;
      tens = 4'(v / 10);
      ones = 4'(v % 10);
      return {tens, ones};
   endfunction

endpackage

// File: rtl/game_countdown_timer_if.sv
// Control/status bundle between the game controller and the countdown timer.
// Optional BCD outputs exist only when GAME_TIMER_BCD_EN is defined.
interface game_countdown_timer_if #(
   parameter int unsigned CNT_W = 6
);
   logic             start;
   logic             pause;
   logic             abort;
   logic [CNT_W-1:0] seconds_left;
   logic             running;
   logic             timer_expired;
   logic             expired_pulse;
   logic             warning;
`ifdef GAME_TIMER_BCD_EN
   logic [3:0]       bcd_tens;
   logic [3:0]       bcd_ones;
`endif

   modport master (
      output start, pause, abort,
      input  seconds_left, running, timer_expired, expired_pulse, warning
`ifdef GAME_TIMER_BCD_EN
      , bcd_tens, bcd_ones
`endif
   );

   modport slave (
      input  start, pause, abort,
      output seconds_left, running, timer_expired, expired_pulse, warning
`ifdef GAME_TIMER_BCD_EN
      , bcd_tens, bcd_ones
`endif
   );
endinterface

// File: rtl/game_countdown_timer_tick_sync_edge.sv
// 2-flop synchronizer plus registered rising-edge detector for slow async inputs.
// pulse_out is a one-cycle strobe three clocks after the input rise is sampled.
module tick_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic pulse_out
);
   logic [2:0] sync_q;
   logic       pulse_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q  <= '0;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[1:0], async_in};
         pulse_q <= sync_q[1] & ~sync_q[2];
      end
   end

   assign pulse_out = pulse_q;
endmodule

// File: rtl/game_countdown_timer.sv
// Game countdown timer: re-timed 1 Hz ticks drive a pausable/abortable countdown.
// Define GAME_TIMER_BCD_EN to add a parallel BCD down-counter on bcd_tens/bcd_ones.
module game_countdown_timer
   import game_pkg::*;
#(
   parameter int unsigned GAME_SECONDS = GAME_SECONDS_DEF,
   parameter int unsigned WARN_SECONDS = WARN_SECONDS_DEF,
   parameter int unsigned CNT_W        = 6
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   tick_1hz,
   game_countdown_timer_if.slave  tmr
);
   localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(GAME_SECONDS);
   localparam logic [CNT_W-1:0] WARN_CNT = CNT_W'(WARN_SECONDS);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   logic             sec_tick;
   timer_state_e     state_q, state_d;
   logic [CNT_W-1:0] secs_q, secs_d;
   logic             running_q, expired_q, pulse_q, pulse_d, warn_q;
`ifdef GAME_TIMER_BCD_EN
   localparam logic [7:0] BCD_RELOAD = to_bcd(GAME_SECONDS);
   logic [7:0]       bcd_q, bcd_d;
`endif

   tick_sync_edge u_tick_sync (
      .clk       (clk),
      .reset     (reset),
      .async_in  (tick_1hz),
      .pulse_out (sec_tick)
   );

   always_comb begin
      state_d = state_q;
      secs_d  = secs_q;
      pulse_d = 1'b0;
`ifdef GAME_TIMER_BCD_EN
      bcd_d   = bcd_q;
`endif
      if (tmr.abort) begin
         state_d = ST_IDLE;
         secs_d  = RELOAD;
`ifdef GAME_TIMER_BCD_EN
         bcd_d   = BCD_RELOAD;
`endif
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               secs_d = RELOAD;
`ifdef GAME_TIMER_BCD_EN
               bcd_d  = BCD_RELOAD;
`endif
               if (tmr.start) state_d = ST_COUNTING;
            end
            ST_COUNTING: begin
               // Pause wins over a coincident tick: that second is not charged.
               if (tmr.pause) begin
                  state_d = ST_PAUSED;
               end else if (sec_tick) begin
                  if (secs_q <= ONE) begin
                     secs_d  = '0;
                     state_d = ST_EXPIRED;
                     pulse_d = 1'b1;
`ifdef GAME_TIMER_BCD_EN
                     bcd_d   = '0;
`endif
                  end else begin
                     secs_d = secs_q - ONE;
`ifdef GAME_TIMER_BCD_EN
                     if (bcd_q[3:0] == 4'd0) bcd_d = {bcd_q[7:4] - 4'd1, 4'd9};
                     else                    bcd_d = {bcd_q[7:4], bcd_q[3:0] - 4'd1};
`endif
                  end
               end
            end
            ST_PAUSED: begin
               if (!tmr.pause) state_d = ST_COUNTING;
            end
            ST_EXPIRED: begin
               secs_d = '0;
               if (tmr.start) begin
                  state_d = ST_COUNTING;
                  secs_d  = RELOAD;
`ifdef GAME_TIMER_BCD_EN
                  bcd_d   = BCD_RELOAD;
`endif
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Status flags are derived from the next state so they move with it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         secs_q    <= RELOAD;
         running_q <= 1'b0;
         expired_q <= 1'b0;
         pulse_q   <= 1'b0;
         warn_q    <= 1'b0;
`ifdef GAME_TIMER_BCD_EN
         bcd_q     <= BCD_RELOAD;
`endif
      end else begin
         state_q   <= state_d;
         secs_q    <= secs_d;
         running_q <= (state_d == ST_COUNTING);
         expired_q <= (state_d == ST_EXPIRED);
         pulse_q   <= pulse_d;
         warn_q    <= ((state_d == ST_COUNTING) || (state_d == ST_PAUSED)) &&
                      (secs_d != '0) && (secs_d <= WARN_CNT);
`ifdef GAME_TIMER_BCD_EN
         bcd_q     <= bcd_d;
`endif
      end
   end

   assign tmr.seconds_left  = secs_q;
   assign tmr.running       = running_q;
   assign tmr.timer_expired = expired_q;
   assign tmr.expired_pulse = pulse_q;
   assign tmr.warning       = warn_q;
`ifdef GAME_TIMER_BCD_EN
   assign tmr.bcd_tens      = bcd_q[7:4];
   assign tmr.bcd_ones      = bcd_q[3:0];
`endif
endmodule

// File: tb/tb_game_countdown_timer.sv
// Randomised and directed bench for game_countdown_timer against a behavioural model.
// Covers the default 30 s instance and a 1 s instance; honours GAME_TIMER_BCD_EN.
module tb_game_countdown_timer;
   localparam int M_IDLE = 0;
   localparam int M_CNT  = 1;
   localparam int M_PAU  = 2;
   localparam int M_EXP  = 3;

   typedef struct {
      int       mode;
      int       secs;
      bit       pulse;
      bit       run;
      bit       exp;
      bit       warn;
      bit [4:0] hist;
   } mdl_t;

   logic clk = 1'b0;
   logic reset_r = 1'b1;
   logic tick_r = 1'b0;
   logic start_r = 1'b0;
   logic pause_r = 1'b0;
   logic abort_r = 1'b0;

   int n_assert = 0;
   int n_fail = 0;
   int pulses0 = 0;
   bit armed = 1'b0;
   mdl_t m0, m1;

   always #5 clk = ~clk;

   game_countdown_timer_if #(.CNT_W(6)) if0 ();
   game_countdown_timer_if #(.CNT_W(1)) if1 ();

   assign if0.start = start_r;
   assign if0.pause = pause_r;
   assign if0.abort = abort_r;
   assign if1.start = start_r;
   assign if1.pause = pause_r;
   assign if1.abort = abort_r;

   game_countdown_timer #(.GAME_SECONDS(30), .WARN_SECONDS(5), .CNT_W(6)) u_dut (
      .clk(clk), .reset(reset_r), .tick_1hz(tick_r), .tmr(if0));

   game_countdown_timer #(.GAME_SECONDS(1), .WARN_SECONDS(0), .CNT_W(1)) u_dut1 (
      .clk(clk), .reset(reset_r), .tick_1hz(tick_r), .tmr(if1));

   task automatic chk(input string name, input int act, input int exp);
      n_assert++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of the timer described by its rules: a raw tick rise sampled
   // three edges ago becomes a counted second at this edge.
   function automatic mdl_t step(input mdl_t m, input bit rst, input bit tk, input bit st,
                                 input bit pa, input bit ab, input int g, input int w);
      bit t;
      if (rst) begin
         m.mode = M_IDLE; m.secs = g; m.hist = '0; m.pulse = 1'b0;
      end else begin
         m.hist = {m.hist[3:0], tk};
         t = m.hist[3] && !m.hist[4];
         m.pulse = 1'b0;
         if (ab) begin
            m.mode = M_IDLE; m.secs = g;
         end else if (m.mode == M_IDLE) begin
            m.secs = g;
            if (st) m.mode = M_CNT;
         end else if (m.mode == M_CNT) begin
            if (pa) m.mode = M_PAU;
            else if (t) begin
               m.secs = (m.secs > 0) ? m.secs - 1 : 0;
               if (m.secs == 0) begin m.mode = M_EXP; m.pulse = 1'b1; end
            end
         end else if (m.mode == M_PAU) begin
            if (!pa) m.mode = M_CNT;
         end else begin
            m.secs = 0;
            if (st) begin m.mode = M_CNT; m.secs = g; end
         end
      end
      m.run  = (m.mode == M_CNT);
      m.exp  = (m.mode == M_EXP);
      m.warn = (m.mode == M_CNT || m.mode == M_PAU) && m.secs > 0 && m.secs <= w;
      return m;
   endfunction

   // Compare process: advance both models on every edge, check just after it.
   always begin
      bit rs, tk, st, pa, ab;
      @(posedge clk);
      rs = reset_r; tk = tick_r; st = start_r; pa = pause_r; ab = abort_r;
      m0 = step(m0, rs, tk, st, pa, ab, 30, 5);
      m1 = step(m1, rs, tk, st, pa, ab, 1, 0);
      if (rs) armed = 1'b1;
      #1;
      if (armed) begin
         if (if0.expired_pulse === 1'b1) pulses0++;
         chk("secs",    int'(if0.seconds_left),  m0.secs);
         chk("running", int'(if0.running),       int'(m0.run));
         chk("expired", int'(if0.timer_expired), int'(m0.exp));
         chk("pulse",   int'(if0.expired_pulse), int'(m0.pulse));
         chk("warning", int'(if0.warning),       int'(m0.warn));
         chk("g1_secs",    int'(if1.seconds_left),  m1.secs);
         chk("g1_running", int'(if1.running),       int'(m1.run));
         chk("g1_expired", int'(if1.timer_expired), int'(m1.exp));
         chk("g1_pulse",   int'(if1.expired_pulse), int'(m1.pulse));
`ifdef GAME_TIMER_BCD_EN
         chk("bcd_tens", int'(if0.bcd_tens), m0.secs / 10);
         chk("bcd_ones", int'(if0.bcd_ones), m0.secs % 10);
         chk("g1_bcd",   int'({if1.bcd_tens, if1.bcd_ones}), m1.secs);
`endif
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_tick();
      tick_r = 1'b1;
      cyc(8);
      tick_r = 1'b0;
      cyc(8);
   endtask

   task automatic tick_until(input int target, input string name);
      int guard = 0;
      while (m0.secs != target && guard < 100) begin
         do_tick();
         guard++;
      end
      chk(name, int'(if0.seconds_left), target);
   endtask

   initial begin
      #2_000_000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      int pcnt;
      int tcnt;
      cyc(3);
      reset_r = 1'b0;
      chk("rst_secs", int'(if0.seconds_left), 30);
      chk("rst_running", int'(if0.running), 0);
      chk("rst_warning", int'(if0.warning), 0);
      pulses0 = 0;

      start_r = 1'b1; cyc(1); start_r = 1'b0;
      chk("start_running", int'(if0.running), 1);
      chk("start_secs", int'(if0.seconds_left), 30);
      do_tick();
      chk("first_dec", int'(if0.seconds_left), 29);

      tick_until(10, "reach_10");
      pause_r = 1'b1;
      repeat (3) do_tick();
      chk("pause_hold", int'(if0.seconds_left), 10);
      chk("pause_running", int'(if0.running), 0);
      pause_r = 1'b0; cyc(2);
      chk("resume_running", int'(if0.running), 1);
      do_tick();
      chk("resume_dec", int'(if0.seconds_left), 9);

      tick_until(6, "reach_6");
      chk("warn_at_6", int'(if0.warning), 0);
      do_tick();
      chk("warn_at_5", int'(if0.warning), 1);
      tick_until(1, "reach_1");
      chk("warn_at_1", int'(if0.warning), 1);
      do_tick();
      chk("expired_secs", int'(if0.seconds_left), 0);
      chk("expired_level", int'(if0.timer_expired), 1);
      chk("expired_warn", int'(if0.warning), 0);
      chk("pulse_once", pulses0, 1);
      do_tick();
      chk("expired_hold", int'(if0.timer_expired), 1);
      chk("pulse_still_once", pulses0, 1);

      start_r = 1'b1; cyc(1); start_r = 1'b0;
      chk("restart_secs", int'(if0.seconds_left), 30);
      chk("restart_running", int'(if0.running), 1);
      chk("restart_expired", int'(if0.timer_expired), 0);

      // Abort lands on the same edge the next second would be counted.
      tick_until(17, "reach_17");
      pcnt = pulses0;
      tick_r = 1'b1; cyc(3);
      abort_r = 1'b1; start_r = 1'b1; cyc(1);
      abort_r = 1'b0; start_r = 1'b0;
      chk("abort_secs", int'(if0.seconds_left), 30);
      chk("abort_running", int'(if0.running), 0);
      chk("abort_no_pulse", pulses0, pcnt);
      cyc(5); tick_r = 1'b0; cyc(8);
      chk("abort_idle_hold", int'(if0.seconds_left), 30);

      start_r = 1'b1; cyc(1); start_r = 1'b0;
      tick_until(12, "reach_12");
      reset_r = 1'b1; cyc(1);
      chk("midrst_secs", int'(if0.seconds_left), 30);
      chk("midrst_running", int'(if0.running), 0);
      chk("midrst_expired", int'(if0.timer_expired), 0);
      chk("midrst_pulse", int'(if0.expired_pulse), 0);
      reset_r = 1'b0; cyc(2);

      tcnt = 0;
      for (int c = 0; c < 6000; c++) begin
         if (tcnt <= 0) begin
            tick_r = ~tick_r;
            tcnt = int'($urandom_range(4, 14));
         end
         tcnt--;
         start_r = ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 59) == 0) pause_r = ~pause_r;
         abort_r = ($urandom_range(0, 399) == 0);
         reset_r = ($urandom_range(0, 1999) == 0);
         cyc(1);
      end
      start_r = 1'b0; pause_r = 1'b0; abort_r = 1'b0; reset_r = 1'b0;
      cyc(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/game_countdown_timer.md
Name: game_countdown_timer

Overview:
- Upstream feeder for the game control FSM: produces its timer_expired input and the seconds-remaining value for the display path.
- Takes the slow 1 Hz increment clock and re-times it into the 100 MHz domain as single-cycle ticks.
- Counts down from GAME_SECONDS once a game starts, supports pause and abort, and flags the final seconds.

Parameters:
- GAME_SECONDS, 30, countdown start value in seconds (1..63).
- WARN_SECONDS, 5, warning asserts while 0 < seconds_left <= WARN_SECONDS (must be < GAME_SECONDS).
- CNT_W, 6, width of seconds_left (must hold GAME_SECONDS).

Ports:
- clk  in  1  100 MHz system clock.
- reset  in  1  reset, synchronous, active-high.
- tick_1hz  in  1  raw 1 Hz increment clock, treated as asynchronous data.
- start  in  1  start request (level or pulse); sampled in IDLE/EXPIRED only.
- pause  in  1  level; holds the count while high.
- abort  in  1  pulse; returns to IDLE from any state.
- seconds_left  out  CNT_W  remaining seconds.
- running  out  1  high in COUNTING.
- timer_expired  out  1  level; high in EXPIRED.
- expired_pulse  out  1  one-cycle strobe on entry to EXPIRED.
- warning  out  1  low-time flag.

Behaviour:
- Tick path: 2-flop synchronizer on tick_1hz, then rising-edge detect.
  - sec_tick is a 1-cycle strobe, 3 clk after the synchronized rise.
  - Synchronizer flops clear on reset.
- States: IDLE, COUNTING, PAUSED, EXPIRED.
- Reset: state = IDLE, seconds_left = GAME_SECONDS, running = 0, timer_expired = 0, expired_pulse = 0, warning = 0, edge-detect history = 0.
- IDLE:
  - seconds_left held at GAME_SECONDS.
  - start = 1 → COUNTING next cycle.
  - The first decrement waits for the next sec_tick after entry; no partial-second credit.
- COUNTING:
  - On sec_tick: seconds_left -= 1.
  - If seconds_left == 1 at that tick: seconds_left → 0, state → EXPIRED, expired_pulse = 1 for that cycle.
  - pause = 1 (no abort) → PAUSED.
  - A sec_tick in the same cycle as pause is ignored; no decrement.
- PAUSED:
  - seconds_left frozen; sec_ticks discarded.
  - pause = 0 → COUNTING.
- EXPIRED:
  - seconds_left = 0, timer_expired = 1.
  - start = 1 → reload GAME_SECONDS and go to COUNTING (restart).
  - pause is ignored.
- abort has priority over start, pause and tick in every state:
  - next state = IDLE, seconds_left = GAME_SECONDS, no expired_pulse.
- reset has priority over everything, mid-count included.
- Outputs are registered and change on the same edge as the state.
  - running = (state == COUNTING).
  - warning is computed from the next-state seconds_left and state, then registered.
  - warning is 0 in IDLE and EXPIRED; it stays asserted in PAUSED if the count is in range.
- Arithmetic:
  - Unsigned CNT_W; never decrements below 0; no wrap.
  - GAME_SECONDS == 1: first tick goes straight to EXPIRED.
- Throughput: at most one decrement per sec_tick; clk-domain inputs need no synchronization.

Optional Feature:
- Macro: GAME_TIMER_BCD_EN.
- Defined:
  - Adds outputs bcd_tens[3:0] and bcd_ones[3:0], registered and updated on the same edge as seconds_left.
  - Maintained as a BCD down-counter in parallel; no divider.
  - Reset / reload value is the BCD of GAME_SECONDS.
  - ones wraps 0 → 9 with a tens borrow.
- Undefined: ports and logic absent; binary seconds_left only.
- Core behaviour is identical in both builds.

Decomposition:
- Package game_pkg:
  - timer state enum (IDLE/COUNTING/PAUSED/EXPIRED, 2-bit);
  - default GAME_SECONDS and WARN_SECONDS constants;
  - function computing CNT_W from GAME_SECONDS;
  - function converting a constant to BCD.
- Sub-module tick_sync_edge:
  - 2FF synchronizer plus rising-edge detector;
  - ports clk, reset, async_in, pulse_out;
  - reused later for the button inputs.

Test Plan:
- Reset, then start = 1 for 1 cycle; apply 30 tick_1hz rises at 1 kHz scaled rate → seconds_left steps 30 → 29 → … → 0; expired_pulse exactly once; timer_expired held high.
- At seconds_left = 10, pause high across 3 ticks then low → value stays 10 during the pause, resumes at 9 on the next tick; state returns to COUNTING.
- Seconds 5..1 → warning = 1; at 6 warning = 0; after expiry warning = 0.
- abort at seconds_left = 17, same cycle as a sec_tick and start → IDLE, seconds_left = 30, no expired_pulse, running = 0.
- From EXPIRED, start → seconds_left = 30, running = 1, timer_expired = 0 next cycle; reset asserted mid-count at 12 → all outputs at reset values on the next edge.
- GAME_TIMER_BCD_EN defined, count 30 → 29 → 20 → 19 → bcd pairs 3/0, 2/9, 2/0, 1/9, tracking seconds_left each cycle.
